// File: rtl/qspi_read_initiator_if.sv
// Request/response port and QSPI pin bundle of the quad-I/O read initiator.
// master = initiator side, slave = requester plus pin/PMOD side.
interface qspi_read_initiator_if;
    logic        start;
    logic [23:0] addr;
    logic [1:0]  sel;
    logic [1:0]  len;
    logic [2:0]  latency;
    logic        busy;
    logic [31:0] data_out;
    logic        data_valid;
    logic [3:0]  qspi_data_in;
    logic [3:0]  qspi_data_out;
    logic [3:0]  qspi_data_oe;
    logic        qspi_clk_out;
    logic        qspi_flash_select;
    logic        qspi_ram_a_select;
    logic        qspi_ram_b_select;

    modport master (
        input  start, addr, sel, len, latency, qspi_data_in,
        output busy, data_out, data_valid, qspi_data_out, qspi_data_oe,
               qspi_clk_out, qspi_flash_select, qspi_ram_a_select, qspi_ram_b_select
    );

    modport slave (
        output start, addr, sel, len, latency, qspi_data_in,
        input  busy, data_out, data_valid, qspi_data_out, qspi_data_oe,
               qspi_clk_out, qspi_flash_select, qspi_ram_a_select, qspi_ram_b_select
    );
endinterface

// File: rtl/qspi_read_initiator.sv
// Quad-I/O fast-read (0xEB) initiator: 1-4 byte reads from the PMOD flash or RAMs,
// with 0-4 cycles of round-trip input latency compensation.
module qspi_read_initiator (
    input  logic                   clk,
    input  logic                   rst,
    qspi_read_initiator_if.master  bus
);
    localparam logic [7:0] CMD_QUAD_READ = 8'hEB;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, MODE, DUMMY, DATA, DONE} state_t;

    state_t      state_q, state_d;
    logic        sck_q;
    logic [4:0]  spi_q, spi_d;
    logic [23:0] addr_q;
    logic [1:0]  sel_q;
    logic [1:0]  len_q;
    logic [2:0]  lat_q;
    logic [3:0]  cap_q;
    logic [2:0]  nib_q;
    logic [3:0]  io_q, io_d;
    logic [3:0]  oe_q, oe_d;
    logic [2:0]  cs_n_q;
    logic        busy_q;
    logic        valid_q;
    logic [31:0] data_q;

    logic [4:0]  spi_end;
    logic [4:0]  nib_bit;
    logic        rise;
    logic        capture;
    logic        last_nib;

    // cap_q delays each data-phase SCK rise by the captured latency to time the sample.
    always_comb begin
        spi_end  = 5'd22 + {2'b00, len_q, 1'b0};
        spi_d    = spi_q + 5'd1;
        rise     = (state_q == DATA) && !sck_q && (spi_q < spi_end);
        capture  = (lat_q == 3'd0) ? rise : cap_q[2'(lat_q - 3'd1)];
        last_nib = (nib_q == {len_q, 1'b1});
        nib_bit  = {nib_q[2:1], ~nib_q[0], 2'b00};
    end

    // Pin values and phase for the SPI cycle that starts on the next SCK fall.
    always_comb begin
        state_d = DATA;
        io_d    = '0;
        oe_d    = '0;
        if (spi_d < 5'd8) begin
            state_d = CMD;
            oe_d    = 4'b0001;
            io_d    = {3'b000, CMD_QUAD_READ[3'd7 - spi_d[2:0]]};
        end else if (spi_d < 5'd14) begin
            state_d = ADDR;
            oe_d    = '1;
            case (spi_d)
                5'd8:    io_d = addr_q[23:20];
                5'd9:    io_d = addr_q[19:16];
                5'd10:   io_d = addr_q[15:12];
                5'd11:   io_d = addr_q[11:8];
                5'd12:   io_d = addr_q[7:4];
                5'd13:   io_d = addr_q[3:0];
                default: io_d = '0;
            endcase
        end else if (spi_d < 5'd16) begin
            state_d = MODE;
            oe_d    = '1;
        end else if (spi_d < 5'd20) begin
            state_d = DUMMY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sck_q   <= 1'b0;
            spi_q   <= '0;
            addr_q  <= '0;
            sel_q   <= '0;
            len_q   <= '0;
            lat_q   <= '0;
            cap_q   <= '0;
            nib_q   <= '0;
            io_q    <= '0;
            oe_q    <= '0;
            cs_n_q  <= '1;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start && !busy_q) begin
                        state_q <= CMD;
                        sck_q   <= 1'b0;
                        spi_q   <= '0;
                        addr_q  <= bus.addr;
                        sel_q   <= bus.sel;
                        len_q   <= bus.len;
                        lat_q   <= (bus.latency > 3'd4) ? 3'd4 : bus.latency;
                        cap_q   <= '0;
                        nib_q   <= '0;
                        io_q    <= {3'b000, CMD_QUAD_READ[7]};
                        oe_q    <= 4'b0001;
                        cs_n_q  <= ~(3'b001 << bus.sel);
                        busy_q  <= 1'b1;
                        data_q  <= '0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    sck_q   <= 1'b0;
                    io_q    <= '0;
                    oe_q    <= '0;
                    cap_q   <= '0;
                    cs_n_q  <= '1;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b1;
                end
                default: begin
                    cap_q <= {cap_q[2:0], rise};
                    if (!sck_q) begin
                        sck_q <= (state_q != DATA) || (spi_q < spi_end);
                    end else begin
                        sck_q   <= 1'b0;
                        spi_q   <= spi_d;
                        io_q    <= io_d;
                        oe_q    <= oe_d;
                        state_q <= state_d;
                    end
                    // A capture may land after SCK has stopped; it overrides the phase update.
                    if (capture) begin
                        if (sel_q != 2'd3) begin
                            data_q[nib_bit +: 4] <= bus.qspi_data_in;
                        end
                        nib_q <= nib_q + 3'd1;
                        if (last_nib) begin
                            state_q <= DONE;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.busy              = busy_q;
    assign bus.data_out          = data_q;
    assign bus.data_valid        = valid_q;
    assign bus.qspi_data_out     = io_q;
    assign bus.qspi_data_oe      = oe_q;
    assign bus.qspi_clk_out      = sck_q;
    assign bus.qspi_flash_select = cs_n_q[0];
    assign bus.qspi_ram_a_select = cs_n_q[1];
    assign bus.qspi_ram_b_select = cs_n_q[2];
endmodule

// File: tb/tb_qspi_read_initiator.sv
// Bench for qspi_read_initiator: PMOD responder with latency buffer, transaction-level
// reference model feeding a scoreboard, and a monitor checking each completion.
`timescale 1ns/1ps
module tb_qspi_read_initiator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    qspi_read_initiator_if bus();
    qspi_read_initiator dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [31:0] data;
        int          done;
        int          sel;
        logic [23:0] addr;
        int          dur;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   model_start = 0;
    int   model_done = 0;
    int   cur_lat = 0;
    logic [7:0] ovr [logic [25:0]];

    int          cs_cnt = 0;
    int          wrong_cs = 0;
    int          rises = 0;
    int          proto_err = 0;
    logic        sck_prev = 1'b0;
    logic        any_low_prev = 1'b0;
    logic [7:0]  cmd_seen = '0;
    logic [23:0] addr_seen = '0;
    logic [3:0]  raw = '0;
    logic [3:0]  hist [0:4] = '{default: 4'h0};

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] mem_byte(int t, logic [23:0] a);
        logic [25:0] k;
        int v;
        k = {t[1:0], a};
        if (ovr.exists(k)) return ovr[k];
        v = int'(a) * 29 + int'(a >> 11) + t * 77 + 3;
        return v[7:0];
    endfunction

    // Transaction-level model: acceptance rule, duration and expected read data.
    always @(posedge clk) begin : model
        int l;
        int lat;
        int dur;
        exp_t e;
        cyc = cyc + 1;
        if (rst) begin
            sbq.delete();
            model_start = 0;
            model_done  = 0;
        end else if (bus.start && cyc > model_done) begin
            l   = int'(bus.len) + 1;
            lat = (bus.latency > 3'd4) ? 4 : int'(bus.latency);
            dur = 40 + 4 * l + lat;
            e.data = '0;
            if (bus.sel != 2'd3)
                for (int b = 0; b < l; b++)
                    e.data[8*b +: 8] = mem_byte(int'(bus.sel), bus.addr + 24'(b));
            e.done = cyc + dur;
            e.sel  = int'(bus.sel);
            e.addr = bus.addr;
            e.dur  = dur;
            sbq.push_back(e);
            model_start = cyc;
            model_done  = cyc + dur;
            cur_lat     = lat;
        end
    end

    // Monitor (scoreboard pop) followed by the PMOD responder and its latency buffer.
    always @(negedge clk) begin : mon
        logic [2:0] cs;
        logic [2:0] want;
        logic [7:0] by;
        int t;
        int j;
        exp_t e;
        cs = {bus.qspi_ram_b_select, bus.qspi_ram_a_select, bus.qspi_flash_select};
        if (rst) begin
            cs_cnt   = 0;
            wrong_cs = 0;
            rises    = 0;
            sck_prev = 1'b0;
            raw      = '0;
        end else begin
            chk("busy", bus.busy, (cyc >= model_start && cyc < model_done) ? 1 : 0);
            if (cs != 3'b111) begin
                cs_cnt++;
                want = 3'b111;
                if (sbq.size() != 0 && sbq[0].sel < 3) want[sbq[0].sel] = 1'b0;
                if (cs != want || want == 3'b111) wrong_cs++;
            end
            if (bus.data_valid) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_valid actual=1 expected=0 (cycle %0d)", cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("data", bus.data_out, e.data);
                    chk("done_cycle", cyc, e.done);
                    chk("cs_low_cycles", cs_cnt, (e.sel == 3) ? 0 : e.dur);
                    chk("wrong_cs", wrong_cs, 0);
                    chk("cs_high_at_done", cs, 3'b111);
                    if (e.sel != 3) begin
                        chk("cmd", cmd_seen, 8'hEB);
                        chk("addr", addr_seen, e.addr);
                        chk("proto", proto_err, 0);
                    end
                end
                cs_cnt   = 0;
                wrong_cs = 0;
            end

            if (cs != 3'b111 && !any_low_prev) begin
                rises     = 0;
                proto_err = 0;
                cmd_seen  = '0;
                addr_seen = '0;
            end
            t = !cs[0] ? 0 : !cs[1] ? 1 : !cs[2] ? 2 : -1;
            if (t >= 0) begin
                if (bus.qspi_clk_out && !sck_prev) begin
                    if (rises < 8) begin
                        if (bus.qspi_data_oe != 4'b0001 || bus.qspi_data_out[3:1] != 3'b000) proto_err++;
                        cmd_seen = {cmd_seen[6:0], bus.qspi_data_out[0]};
                    end else if (rises < 14) begin
                        if (bus.qspi_data_oe != 4'b1111) proto_err++;
                        addr_seen = {addr_seen[19:0], bus.qspi_data_out};
                    end else if (rises < 16) begin
                        if (bus.qspi_data_oe != 4'b1111 || bus.qspi_data_out != 4'h0) proto_err++;
                    end else if (bus.qspi_data_oe != 4'b0000) begin
                        proto_err++;
                    end
                    rises++;
                end else if (!bus.qspi_clk_out && sck_prev && rises >= 20) begin
                    j   = rises - 20;
                    by  = mem_byte(t, addr_seen + 24'(j / 2));
                    raw = (j % 2 == 0) ? by[7:4] : by[3:0];
                end
            end else begin
                raw = '0;
            end
            sck_prev = bus.qspi_clk_out;
        end
        any_low_prev = (cs != 3'b111) && !rst;
        for (int k = 4; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = raw;
        bus.qspi_data_in = hist[cur_lat];
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sbq.size() != 0 || model_done >= cyc) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            checks++;
            failures++;
            $display("FAIL timeout actual=pending expected=complete (cycle %0d)", cyc);
        end
        @(negedge clk);
    endtask

    task automatic req(int s, logic [23:0] a, int l, int lat);
        @(negedge clk);
        bus.sel     = 2'(s);
        bus.addr    = a;
        bus.len     = 2'(l);
        bus.latency = 3'(lat);
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
        wait_idle();
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_flash_cs"}, bus.qspi_flash_select, 1);
        chk({tag, "_ram_a_cs"}, bus.qspi_ram_a_select, 1);
        chk({tag, "_ram_b_cs"}, bus.qspi_ram_b_select, 1);
        chk({tag, "_sck"}, bus.qspi_clk_out, 0);
        chk({tag, "_oe"}, bus.qspi_data_oe, 0);
        chk({tag, "_io"}, bus.qspi_data_out, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_valid"}, bus.data_valid, 0);
        chk({tag, "_data"}, bus.data_out, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start   = 1'b0;
        bus.addr    = '0;
        bus.sel     = '0;
        bus.len     = '0;
        bus.latency = '0;
        ovr[{2'd0, 24'h000010}] = 8'h11;
        ovr[{2'd0, 24'h000011}] = 8'h22;
        ovr[{2'd0, 24'h000012}] = 8'h33;
        ovr[{2'd0, 24'h000013}] = 8'h44;
        ovr[{2'd2, 24'h00ABCD}] = 8'hA5;
        ovr[{2'd0, 24'h000200}] = 8'hDE;
        ovr[{2'd0, 24'h000201}] = 8'hAD;
        ovr[{2'd0, 24'h000202}] = 8'hBE;
        ovr[{2'd0, 24'h000203}] = 8'hEF;

        repeat (3) @(negedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk);
        #2 rst = 1'b0;

        req(0, 24'h000010, 3, 0);
        req(2, 24'h00ABCD, 0, 3);
        for (int l = 0; l < 8; l++) req(0, 24'h000200, 3, l);

        // start held high across several transfers
        @(negedge clk);
        bus.sel = 2'd1; bus.addr = 24'h123456; bus.len = 2'd3; bus.latency = 3'd0;
        bus.start = 1'b1;
        repeat (130) @(negedge clk);
        bus.start = 1'b0;
        wait_idle();

        // reset in the middle of the address phase
        @(negedge clk);
        bus.sel = 2'd0; bus.addr = 24'h0F0F0F; bus.len = 2'd2; bus.latency = 3'd1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (24) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("midreset");
        @(negedge clk);
        #2 rst = 1'b0;
        req(1, 24'h0F0F0F, 2, 1);

        req(3, 24'h000010, 3, 2);

        for (int i = 0; i < 20; i++)
            req(int'($urandom_range(0, 3)), 24'($urandom), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 7)));

        chk("drain", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/qspi_read_initiator.md
# qspi_read_initiator

Synthesizable QSPI read initiator that issues quad-I/O fast-read (0xEB) transactions to the flash or either RAM on the QSPI PMOD and returns 1–4 bytes. It sits between a simple request port (CPU fetch or DMA) and the shared uio QSPI pins. It is the initiator counterpart of the simulated PMOD responder. It compensates a configurable 0–4 cycle round-trip input latency, matching the bench's latency buffer.

## Interface

- No parameters; command, dummy count and latency clamp are fixed.
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request strobe; accepted only when busy=0
- addr  in  24  byte address, captured on accept
- sel  in  2  target: 0 flash, 1 RAM A, 2 RAM B; 3 treated as no-op (accepted, no CS asserted, completes normally with data_out=0)
- len  in  2  byte count minus one (0..3), captured on accept
- latency  in  3  input latency in clk cycles; values 5–7 treated as 4; captured on accept
- busy  out  1  high from accept until completion
- data_out  out  32  read data; byte 0 in [7:0]; unread bytes zero; held until next accept
- data_valid  out  1  one-cycle completion pulse
- qspi_data_in  in  4  IO[3:0] from pins
- qspi_data_out  out  4  IO[3:0] drive values
- qspi_data_oe  out  4  per-bit output enable, 1 = drive
- qspi_clk_out  out  1  SCK
- qspi_flash_select, qspi_ram_a_select, qspi_ram_b_select  out  1 each  active-low chip selects

## Operation

- States: IDLE, CMD, ADDR, MODE, DUMMY, DATA, DONE.
- IDLE: selects high, SCK low, oe=0000, data_out_pins=0000. On start&!busy: latch inputs, clear data_out, drop the selected CS, set busy, go to CMD.
- Each SPI cycle is 2 clk cycles: SCK low then SCK high. Outputs change only while SCK is low (on the edge that drops SCK).
- CMD: 8 SPI cycles, 0xEB MSB first on IO0; oe=0001, IO[3:1]=0.
- ADDR: 6 SPI cycles, addr nibbles MSB first on IO[3:0]; oe=1111.
- MODE: 2 SPI cycles driving 0x0 (mode byte 0x00, no continuous-read); oe=1111.
- DUMMY: 4 SPI cycles, oe=0000.
- DATA: 2L SPI cycles, L=len+1; oe=0000. Nibble j (j=0..2L−1) is captured into byte j/2, high nibble first.
- DONE: after the final capture, raise CS, pulse data_valid, clear busy, return to IDLE.
- Reset at any time: immediately all selects high, SCK low, oe=0000, busy=0, data_valid=0, data_out=0; the in-flight request is discarded.
- start while busy=1 is ignored; no queueing.

## Timing

- E0 = accept edge. After E0: CS low, SCK low, IO0 = cmd bit 7.
- SPI cycle i: SCK rises at E(2i+1), falls at E(2i+2); next cycle's outputs are presented at E(2i+2).
- Data nibble j is SPI cycle 20+j. Its SCK rise is E(41+2j). The nibble is captured from qspi_data_in at E(41+2j+lat), lat = min(latency,4).
- After the last SCK rise at E(39+4L), SCK stays low.
- Completion edge EC = E(40+4L+lat): CS high, busy 0, data_valid 1 for exactly one cycle, data_out final.
- Transaction time = 40+4L+lat cycles: 4-byte, lat 0 → 56 cycles; 1-byte, lat 4 → 48 cycles.
- A start sampled at EC+1 is accepted, giving back-to-back transactions with one idle cycle (CS high for ≥1 cycle).
- Reset values of all outputs: selects 1, qspi_clk_out 0, qspi_data_oe 0000, qspi_data_out 0000, busy 0, data_valid 0, data_out 0.

## Test plan

- Flash, addr 0x000010, len 3, latency 0, sim PMOD loaded with 0x11 22 33 44 at 0x10 → data_out=0x44332211 at cycle 56; flash CS low for exactly 56 cycles; IO0 shows 0xEB then nibbles 0,0,0,0,1,0.
- RAM B, len 0, latency 3, byte 0xA5 at addr → data_out=0x000000A5; data_valid at cycle 47; RAM A and flash CS stay high throughout.
- Latency sweep 0..7 on a fixed 4-byte word with the bench latency buffer matching → identical data for all settings; latency 5–7 complete at the same cycle as 4.
- start pulsed every cycle during a transfer → only the first is accepted; the next accept falls exactly at EC+1; one CS-high gap cycle is observed.
- rst asserted at cycle 25 (mid-address) → same cycle: all CS high, oe=0000, busy=0; a new request after release completes correctly.
- sel=3 → no CS asserted, data_valid after the normal duration, data_out=0.
